// File: rtl/adler32_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adler32_pkg
// Purpose  : Shared Adler-32 constants, state encoding and byte order.
// Revision : 1.0
// ============================================================================
package adler32_pkg;

   localparam int unsigned C_ADLER_MOD      = 65521;
   localparam int unsigned C_DATA_WD        = 32;
   localparam int unsigned C_BYTES_PER_WORD = 4;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RUN   = 3'd1,
      ST_DRAIN = 3'd2,
      ST_WCHK  = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   // Byte 0 of a payload word sits in the MSBs and is summed first.
   function automatic logic [7:0] lead_byte(input logic [31:0] word);
      return word[31:24];
   endfunction

endpackage
`default_nettype wire

// File: rtl/adler32_chk_if.sv
`default_nettype none
// ============================================================================
// Module   : adler32_chk_if
// Purpose  : Payload, checksum and result signals of the Adler-32 checker.
// Revision : 1.0
// ============================================================================
interface adler32_chk_if
   import adler32_pkg::*;
#(
   parameter int DATA_WD = C_DATA_WD
);
   logic               start_i;
   logic               val_i;
   logic [DATA_WD-1:0] dat_i;
   logic               lst_i;
   logic [1:0]         keep_i;
   logic               rdy_o;
   logic               chk_val_i;
   logic [31:0]        chk_dat_i;
   logic               done_o;
   logic               ok_o;
   logic               err_o;
   logic [31:0]        sum_o;

   modport slave (
      input  start_i, val_i, dat_i, lst_i, keep_i, chk_val_i, chk_dat_i,
      output rdy_o, done_o, ok_o, err_o, sum_o
   );

   modport master (
      output start_i, val_i, dat_i, lst_i, keep_i, chk_val_i, chk_dat_i,
      input  rdy_o, done_o, ok_o, err_o, sum_o
   );
endinterface
`default_nettype wire

// File: rtl/adler32_byte_upd.sv
`default_nettype none
// ============================================================================
// Module   : adler32_byte_upd
// Purpose  : One-byte Adler-32 step (A,B,d) -> (A',B') with modular reduction.
// Revision : 1.0
// ============================================================================
module adler32_byte_upd
   import adler32_pkg::*;
#(
   parameter int unsigned MOD = C_ADLER_MOD
) (
   input  wire logic [15:0] i_a,
   input  wire logic [15:0] i_b,
   input  wire logic [7:0]  i_d,
   output logic      [15:0] o_a,
   output logic      [15:0] o_b
);
   localparam logic [16:0] C_MOD17 = 17'(MOD);

   logic [16:0] w_a_sum;
   logic [16:0] w_b_sum;

   // Both operands are already reduced and d <= 255, so one subtract suffices.
   assign w_a_sum = {1'b0, i_a} + {9'd0, i_d};
   assign o_a     = 16'((w_a_sum >= C_MOD17) ? (w_a_sum - C_MOD17) : w_a_sum);
   assign w_b_sum = {1'b0, i_b} + {1'b0, o_a};
   assign o_b     = 16'((w_b_sum >= C_MOD17) ? (w_b_sum - C_MOD17) : w_b_sum);

endmodule
`default_nettype wire

// File: rtl/adler32_chk.sv
`default_nettype none
// ============================================================================
// Module   : adler32_chk
// Purpose  : Receive-side Adler-32 checker; sums payload bytes and compares
//            the result with the big-endian zlib trailer.
// Revision : 1.0
// ============================================================================
module adler32_chk
   import adler32_pkg::*;
#(
   parameter int          DATA_WD = C_DATA_WD,
   parameter int unsigned MOD     = C_ADLER_MOD
) (
   input wire logic      clk,
   input wire logic      rst,
   adler32_chk_if.slave  bus
);
   state_t             r_state;
   logic [15:0]        r_a;
   logic [15:0]        r_b;
   logic [DATA_WD-1:0] r_sr;
   logic [2:0]         r_cnt;
   logic               r_chk_vld;
   logic [31:0]        r_chk;
   logic               r_rdy;
   logic               r_done;
   logic               r_ok;
   logic               r_err;
   logic [31:0]        r_sum;

   logic [15:0]        w_a_n;
   logic [15:0]        w_b_n;
   logic               w_chk_have;
   logic [31:0]        w_chk_eff;
   logic [31:0]        w_sum_now;
   logic               w_cmp_go;

   adler32_byte_upd #(
      .MOD (MOD)
   ) u_byte_upd (
      .i_a (r_a),
      .i_b (r_b),
      .i_d (lead_byte(r_sr)),
      .o_a (w_a_n),
      .o_b (w_b_n)
   );

   // A checksum arriving on the compare edge is used directly; a newer one wins.
   assign w_chk_have = r_chk_vld | bus.chk_val_i;
   assign w_chk_eff  = bus.chk_val_i ? bus.chk_dat_i : r_chk;
   assign w_sum_now  = (r_cnt != 3'd0) ? {w_b_n, w_a_n} : {r_b, r_a};

   always_comb begin
      w_cmp_go = 1'b0;
      case (r_state)
         ST_RUN:   w_cmp_go = w_chk_have && bus.lst_i && !bus.val_i && (r_cnt == 3'd0);
         ST_DRAIN: w_cmp_go = w_chk_have && (r_cnt == 3'd1);
         ST_WCHK:  w_cmp_go = w_chk_have;
         default:  w_cmp_go = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst || bus.start_i) begin
         r_state   <= rst ? ST_IDLE : ST_RUN;
         r_rdy     <= !rst;
         r_a       <= 16'd1;
         r_b       <= 16'd0;
         r_sr      <= '0;
         r_cnt     <= 3'd0;
         r_chk_vld <= 1'b0;
         r_chk     <= 32'd0;
         r_done    <= 1'b0;
         r_ok      <= 1'b0;
         r_err     <= 1'b0;
         r_sum     <= 32'd0;
      end else begin
         r_done <= 1'b0;

         if (r_cnt != 3'd0) begin
            r_a   <= w_a_n;
            r_b   <= w_b_n;
            r_sr  <= r_sr << 8;
            r_cnt <= r_cnt - 3'd1;
         end

         if (bus.chk_val_i &&
             (r_state == ST_RUN || r_state == ST_DRAIN || r_state == ST_WCHK)) begin
            r_chk_vld <= 1'b1;
            r_chk     <= bus.chk_dat_i;
         end

         case (r_state)
            ST_RUN: begin
               if (bus.val_i && r_rdy) begin
                  r_sr  <= bus.dat_i;
                  r_cnt <= bus.lst_i ? (3'({1'b0, bus.keep_i}) + 3'd1)
                                     : 3'(C_BYTES_PER_WORD);
                  r_rdy <= 1'b0;
                  if (bus.lst_i)
                     r_state <= ST_DRAIN;
               end else if (bus.lst_i && !bus.val_i && (r_cnt == 3'd0)) begin
                  r_rdy   <= 1'b0;
                  r_state <= ST_WCHK;
               end else begin
                  // Ready again in the cycle that consumes the final held byte.
                  r_rdy <= (r_cnt <= 3'd2);
               end
            end
            ST_DRAIN: begin
               if (r_cnt == 3'd1)
                  r_state <= ST_WCHK;
            end
            default: ;
         endcase

         if (w_cmp_go) begin
            r_done    <= 1'b1;
            r_sum     <= w_sum_now;
            r_ok      <= (w_sum_now == w_chk_eff);
            r_err     <= (w_sum_now != w_chk_eff);
            r_chk_vld <= 1'b0;
            r_state   <= ST_DONE;
         end
      end
   end

   assign bus.rdy_o  = r_rdy;
   assign bus.done_o = r_done;
   assign bus.ok_o   = r_ok;
   assign bus.err_o  = r_err;
   assign bus.sum_o  = r_sum;

endmodule
`default_nettype wire

// File: tb/tb_adler32_chk.sv
`default_nettype none
// ============================================================================
// Module   : tb_adler32_chk
// Purpose  : Directed self-checking bench for adler32_chk.
// Revision : 1.0
// ============================================================================
module tb_adler32_chk;
   import adler32_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   adler32_chk_if bus ();

   adler32_chk dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_start();
      bus.start_i = 1'b1;
      tick(1);
      bus.start_i = 1'b0;
   endtask

   task automatic send_chk(input logic [31:0] d);
      bus.chk_val_i = 1'b1;
      bus.chk_dat_i = d;
      tick(1);
      bus.chk_val_i = 1'b0;
   endtask

   // acc = cycle count just after the accepting edge
   task automatic send_word(input logic [31:0] d, input logic lst, input logic [1:0] k,
                            output int acc);
      int n = 0;
      bus.val_i  = 1'b1;
      bus.dat_i  = d;
      bus.lst_i  = lst;
      bus.keep_i = k;
      while (bus.rdy_o !== 1'b1 && n < 64) begin
         tick(1);
         n++;
      end
      if (bus.rdy_o !== 1'b1) begin
         check("rdy_timeout", 32'd0, 32'd1);
         acc = cyc;
      end else begin
         tick(1);
         acc = cyc;
      end
      bus.val_i = 1'b0;
      bus.lst_i = 1'b0;
   endtask

   // lat = edges from 'from' until done_o is seen high
   task automatic wait_done(input int from, output int lat);
      int n = 0;
      while (bus.done_o !== 1'b1 && n < 64) begin
         tick(1);
         n++;
      end
      if (bus.done_o !== 1'b1) begin
         check("done_timeout", 32'd0, 32'd1);
         lat = -1;
      end else begin
         lat = cyc - from;
      end
   endtask

   initial begin
      int acc;
      int acc_prev;
      int lat;
      int t0;
      logic seen;

      bus.start_i   = 1'b0;
      bus.val_i     = 1'b0;
      bus.dat_i     = 32'd0;
      bus.lst_i     = 1'b0;
      bus.keep_i    = 2'd0;
      bus.chk_val_i = 1'b0;
      bus.chk_dat_i = 32'd0;

      // Reset values
      tick(3);
      rst = 1'b0;
      tick(1);
      check("rst_rdy",  {31'd0, bus.rdy_o},  32'd0);
      check("rst_done", {31'd0, bus.done_o}, 32'd0);
      check("rst_ok",   {31'd0, bus.ok_o},   32'd0);
      check("rst_err",  {31'd0, bus.err_o},  32'd0);
      check("rst_sum",  bus.sum_o,           32'd0);

      // Single word, checksum latched first: last byte at accept+4, done visible after it
      pulse_start();
      check("t1_rdy_after_start", {31'd0, bus.rdy_o}, 32'd1);
      send_chk(32'h0040001b);
      send_word(32'h04090409, 1'b1, 2'd3, acc);
      check("t1_rdy_in_drain", {31'd0, bus.rdy_o}, 32'd0);
      wait_done(acc, lat);
      check("t1_latency", 32'(lat), 32'd4);
      check("t1_ok",  {31'd0, bus.ok_o},  32'd1);
      check("t1_err", {31'd0, bus.err_o}, 32'd0);
      check("t1_sum", bus.sum_o, 32'h0040001b);
      tick(1);
      check("t1_done_pulse", {31'd0, bus.done_o}, 32'd0);
      check("t1_ok_held",    {31'd0, bus.ok_o},   32'd1);

      // Same stream, wrong checksum arriving in WCHK
      pulse_start();
      check("t2_ok_cleared",  {31'd0, bus.ok_o}, 32'd0);
      check("t2_sum_cleared", bus.sum_o,         32'd0);
      send_word(32'h04090409, 1'b1, 2'd3, acc);
      tick(6);
      check("t2_no_done_wchk", {31'd0, bus.done_o}, 32'd0);
      check("t2_rdy_wchk",     {31'd0, bus.rdy_o},  32'd0);
      t0 = cyc + 1;
      send_chk(32'h0040001c);
      wait_done(t0, lat);
      check("t2_latency", 32'(lat), 32'd0);
      check("t2_err", {31'd0, bus.err_o}, 32'd1);
      check("t2_ok",  {31'd0, bus.ok_o},  32'd0);
      check("t2_sum", bus.sum_o, 32'h0040001b);

      // "Wikipedia" at full rate
      pulse_start();
      send_chk(32'h11E60398);
      send_word(32'h57696B69, 1'b0, 2'd0, acc_prev);
      check("t3_rdy_low_after_accept", {31'd0, bus.rdy_o}, 32'd0);
      send_word(32'h70656469, 1'b0, 2'd0, acc);
      check("t3_spacing_1", 32'(acc - acc_prev), 32'd4);
      acc_prev = acc;
      send_word(32'h61000000, 1'b1, 2'd0, acc);
      check("t3_spacing_2", 32'(acc - acc_prev), 32'd4);
      wait_done(acc, lat);
      check("t3_latency", 32'(lat), 32'd1);
      check("t3_sum", bus.sum_o, 32'h11E60398);
      check("t3_ok",  {31'd0, bus.ok_o}, 32'd1);

      // Empty stream
      pulse_start();
      bus.lst_i = 1'b1;
      tick(1);
      bus.lst_i = 1'b0;
      tick(2);
      check("t4_no_done_early", {31'd0, bus.done_o}, 32'd0);
      t0 = cyc + 1;
      send_chk(32'h00000001);
      wait_done(t0, lat);
      check("t4_latency", 32'(lat), 32'd0);
      check("t4_sum", bus.sum_o, 32'h00000001);
      check("t4_ok",  {31'd0, bus.ok_o}, 32'd1);

      // Modulo wrap: 4096 bytes of 0xFF
      pulse_start();
      send_chk(32'h8161F0E2);
      for (int i = 0; i < 1024; i++)
         send_word(32'hFFFFFFFF, (i == 1023), 2'd3, acc);
      wait_done(acc, lat);
      check("t5_sum", bus.sum_o, 32'h8161F0E2);
      check("t5_ok",  {31'd0, bus.ok_o}, 32'd1);

      // Abort mid-DRAIN with start and checksum together; checksum must be dropped
      pulse_start();
      send_word(32'h04090409, 1'b1, 2'd3, acc);
      tick(1);
      bus.start_i   = 1'b1;
      bus.chk_val_i = 1'b1;
      bus.chk_dat_i = 32'h0040001b;
      tick(1);
      bus.start_i   = 1'b0;
      bus.chk_val_i = 1'b0;
      check("t6_rdy_after_abort", {31'd0, bus.rdy_o}, 32'd1);
      check("t6_sum_cleared",     bus.sum_o,          32'd0);
      seen = 1'b0;
      send_word(32'h04090409, 1'b1, 2'd3, acc);
      for (int i = 0; i < 10; i++) begin
         if (bus.done_o === 1'b1) seen = 1'b1;
         tick(1);
      end
      check("t6_no_done", {31'd0, seen}, 32'd0);
      t0 = cyc + 1;
      send_chk(32'h0040001b);
      wait_done(t0, lat);
      check("t6_latency", 32'(lat), 32'd0);
      check("t6_sum", bus.sum_o, 32'h0040001b);
      check("t6_ok",  {31'd0, bus.ok_o}, 32'd1);

      // Reset from DONE clears held result
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      check("t7_ok_rst",  {31'd0, bus.ok_o}, 32'd0);
      check("t7_sum_rst", bus.sum_o,         32'd0);

      // Reset mid-RUN
      pulse_start();
      send_word(32'h12345678, 1'b0, 2'd0, acc);
      tick(3);
      check("t8_rdy_run", {31'd0, bus.rdy_o}, 32'd1);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      check("t8_rdy",  {31'd0, bus.rdy_o},  32'd0);
      check("t8_done", {31'd0, bus.done_o}, 32'd0);
      check("t8_ok",   {31'd0, bus.ok_o},   32'd0);
      check("t8_err",  {31'd0, bus.err_o},  32'd0);
      check("t8_sum",  bus.sum_o,           32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
